// File: rtl/serial_packet_rx.sv
// serial_packet_rx: frames UART bytes as sync/length/payload/checksum packets and
// holds each verified packet in a buffer until the consumer acknowledges it.
module serial_packet_rx #(
  parameter int BAUDRATE        = 115200,
  parameter int CLOCK_FREQUENCY = 48000000,
  parameter int MAX_PAYLOAD     = 16,
  parameter int TIMEOUT_BYTES   = 4,
  localparam int LW = $clog2(MAX_PAYLOAD + 1),
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  output logic          o_Pkt_Valid,
  output logic [LW-1:0] o_Pkt_Len,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [7:0]    o_Rd_Data,
  input  logic          i_Pkt_Ack,
  output logic          o_Err_Pulse,
  output logic [1:0]    o_Err_Code,
  output logic          o_Overrun
);

  localparam int TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * (CLOCK_FREQUENCY / BAUDRATE);
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  logic          err_pulse_q, err_pulse_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    rd_word;
  logic          buf_we;
  logic          len_ok, last_byte, tmo_hit, in_frame;

  logic [7:0] buf_mem [MAX_PAYLOAD];

  assign len_ok    = (i_Rx_Byte != 8'd0) && (int'(i_Rx_Byte) <= MAX_PAYLOAD);
  assign last_byte = (LW'(idx_q) == (len_q - LW'(1)));
  assign in_frame  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  // A byte strobe in the expiry cycle takes priority over the timeout.
  assign tmo_hit   = in_frame && !i_Rx_DV && (tmo_q == TW'(TIMEOUT_CLKS - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pkt_len_d   = pkt_len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    ovr_d       = 1'b0;
    buf_we      = 1'b0;
    tmo_d       = (i_Rx_DV || !in_frame) ? '0 : tmo_q + TW'(1);
    case (state_q)
      S_HUNT: if (i_Rx_DV && i_Rx_Byte == SYNC) state_d = S_LEN;
      S_LEN: if (i_Rx_DV) begin
        if (len_ok) begin
          len_d   = LW'(i_Rx_Byte);
          sum_d   = i_Rx_Byte;
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end else begin
          err_pulse_d = 1'b1;
          err_code_d  = 2'b10;
          state_d     = S_HUNT;
        end
      end
      S_PAYLOAD: if (i_Rx_DV) begin
        buf_we = 1'b1;
        sum_d  = sum_q + i_Rx_Byte;
        idx_d  = idx_q + AW'(1);
        if (last_byte) state_d = S_CHECK;
      end
      S_CHECK: if (i_Rx_DV) begin
        if (i_Rx_Byte == sum_q) begin
          valid_d   = 1'b1;
          pkt_len_d = len_q;
          state_d   = S_HOLD;
        end else begin
          err_pulse_d = 1'b1;
          err_code_d  = 2'b01;
          state_d     = S_HUNT;
        end
      end
      S_HOLD: begin
        if (i_Rx_DV) ovr_d = 1'b1;
        if (i_Pkt_Ack) begin
          valid_d = 1'b0;
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
    if (tmo_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = 2'b11;
      state_d     = S_HUNT;
      tmo_d       = '0;
    end
  end

  // Payload storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge i_Clock) begin
    if (buf_we) buf_mem[idx_q] <= i_Rx_Byte;
  end

  generate
    if (MAX_PAYLOAD == (1 << AW)) begin : g_full_range
      assign rd_word = buf_mem[i_Rd_Addr];
    end else begin : g_part_range
      assign rd_word = (int'(i_Rd_Addr) < MAX_PAYLOAD) ? buf_mem[i_Rd_Addr] : 8'h00;
    end
  endgenerate

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      pkt_len_q   <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'b00;
      ovr_q       <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pkt_len_q   <= pkt_len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      ovr_q       <= ovr_d;
      rd_data_q   <= rd_word;
    end
  end

  assign o_Pkt_Valid = valid_q;
  assign o_Pkt_Len   = pkt_len_q;
  assign o_Rd_Data   = rd_data_q;
  assign o_Err_Pulse = err_pulse_q;
  assign o_Err_Code  = err_code_q;
  assign o_Overrun   = ovr_q;

endmodule

// File: tb/tb_serial_packet_rx.sv
// Scoreboard bench for serial_packet_rx: stimulus queues expected events and reads,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_serial_packet_rx;

  localparam int BAUD = 115200;
  localparam int CLKF = 1152000;
  localparam int MP   = 16;
  localparam int TOB  = 4;
  localparam int T    = TOB * 10 * (CLKF / BAUD);

  typedef struct { int kind; int val; int cyc; } ev_t;   // kind: 0 pkt, 1 err, 2 overrun
  typedef struct { logic [7:0] data; int cyc; } rd_t;

  logic       clk, rst_n, rx_dv, pkt_ack;
  logic [7:0] rx_byte, rd_data;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr;
  logic       pkt_valid, err_pulse, overrun;
  logic [1:0] err_code;

  ev_t ev_q[$];
  rd_t rd_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  logic valid_prev = 1'b0;

  serial_packet_rx #(
    .BAUDRATE(BAUD), .CLOCK_FREQUENCY(CLKF), .MAX_PAYLOAD(MP), .TIMEOUT_BYTES(TOB)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Pkt_Valid(pkt_valid), .o_Pkt_Len(pkt_len), .i_Rd_Addr(rd_addr),
    .o_Rd_Data(rd_data), .i_Pkt_Ack(pkt_ack), .o_Err_Pulse(err_pulse),
    .o_Err_Code(err_code), .o_Overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else $display("ok   %s = %0h", name, act);
  endtask

  task automatic check_event(input int kind, input int val);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind=%0d val=%0h at cyc %0d", kind, val, cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0h cyc=%0d expected kind=%0d val=%0h cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end else $display("ok   event kind=%0d val=%0h cyc=%0d", kind, val, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_valid && !valid_prev) check_event(0, int'(pkt_len));
      if (err_pulse) check_event(1, int'(err_code));
      if (overrun) check_event(2, 0);
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        checks++;
        if (rd_data !== rd_q[0].data) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h at cyc %0d", rd_data, rd_q[0].data, cyc);
        end else $display("ok   rd_data = %0h cyc=%0d", rd_data, cyc);
        void'(rd_q.pop_front());
      end
    end
    valid_prev = pkt_valid;
  end

  task automatic expect_ev(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = at;
    ev_q.push_back(e);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    rd_t r;
    r.data = exp; r.cyc = cyc + 1;
    rd_q.push_back(r);
    rd_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    @(posedge clk); #1;
    pkt_ack = 1'b0;
    chk("valid_after_ack", int'(pkt_valid), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(pkt_valid), 0);
    chk({tag, "_len"}, int'(pkt_len), 0);
    chk({tag, "_rd_data"}, int'(rd_data), 0);
    chk({tag, "_err_pulse"}, int'(err_pulse), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; pkt_ack = 1'b0; rd_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Noise then a good frame
    send(8'h00); send(8'hFF); send(8'h3C);
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    expect_ev(0, 3, cyc + 1);
    send(8'h63);
    rd(4'd0, 8'h10); rd(4'd1, 8'h20); rd(4'd2, 8'h30);

    // Overrun while held leaves the buffer intact
    expect_ev(2, 0, cyc + 1);
    send(8'h55);
    rd(4'd0, 8'h10); rd(4'd1, 8'h20); rd(4'd2, 8'h30);
    ack();

    // Sync on the cycle right after Ack; checksum that wraps to zero
    send(8'hA5); send(8'h02); send(8'hFF); send(8'hFF);
    expect_ev(0, 2, cyc + 1);
    send(8'h00);
    rd(4'd0, 8'hFF); rd(4'd1, 8'hFF); rd(4'd2, 8'h30);

    // DV and Ack together: overrun, back to HUNT, the A5 is not a sync
    expect_ev(2, 0, cyc + 1);
    rx_dv = 1'b1; rx_byte = 8'hA5; pkt_ack = 1'b1;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_byte = 8'h00; pkt_ack = 1'b0;
    chk("valid_after_dv_ack", int'(pkt_valid), 0);
    send(8'h01); send(8'h07); send(8'h08);

    // Bad checksum
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    expect_ev(1, 1, cyc + 1);
    send(8'h64);
    chk("valid_after_bad_chk", int'(pkt_valid), 0);

    // Bad lengths, then the maximum legal length
    send(8'hA5);
    expect_ev(1, 2, cyc + 1);
    send(8'h00);
    send(8'hA5);
    expect_ev(1, 2, cyc + 1);
    send(8'h11);
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    expect_ev(0, 16, cyc + 1);
    send(8'h98);
    rd(4'd0, 8'h01); rd(4'd15, 8'h10);
    ack();

    // Inter-byte timeout fires exactly T cycles after the last strobe
    send(8'hA5); send(8'h02); send(8'h10);
    expect_ev(1, 3, cyc + T);
    repeat (T + 5) begin @(posedge clk); #1; end
    send(8'hA5); send(8'h01); send(8'h07);
    expect_ev(0, 1, cyc + 1);
    send(8'h08);
    rd(4'd0, 8'h07);
    ack();

    // Asynchronous reset in the middle of a payload
    rd_addr = 4'd0;
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20);
    chk("rd_before_reset", int'(rd_data), 8'h10);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'hA5); send(8'h02); send(8'h33); send(8'h44);
    expect_ev(0, 2, cyc + 1);
    send(8'h79);
    rd(4'd0, 8'h33); rd(4'd1, 8'h44);
    ack();

    repeat (3) begin @(posedge clk); #1; end
    chk("pending_events", ev_q.size(), 0);
    chk("pending_reads", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_packet_rx.md
# serial_packet_rx

Framing stage directly downstream of the UART receiver: consumes its one-cycle byte strobe and byte, hunts for a sync byte, and collects a length-prefixed payload into an internal buffer. It verifies an 8-bit additive checksum and presents each good packet to the application through a random-access read port. The packet stays held until the consumer acknowledges it. Malformed, stalled or overrun traffic is discarded and flagged.

## Interface
- BAUDRATE, 115200: UART bit rate; used only to size the timeout.
- CLOCK_FREQUENCY, 48000000: i_Clock frequency in Hz.
- MAX_PAYLOAD, 16: buffer depth in bytes; legal lengths are 1..MAX_PAYLOAD.
- TIMEOUT_BYTES, 4: inter-byte timeout in byte times.
  - TIMEOUT_CLKS = TIMEOUT_BYTES*10*(CLOCK_FREQUENCY/BAUDRATE).
- Derived widths:
  - LW = $clog2(MAX_PAYLOAD+1)
  - AW = $clog2(MAX_PAYLOAD), minimum 1
- i_Clock  in  1  single clock; everything is posedge.
- i_Rst_n  in  1  reset, asynchronous and active-low.
- i_Rx_DV  in  1  one-cycle byte-valid strobe from the UART receiver.
- i_Rx_Byte  in  8  received byte; sampled only when i_Rx_DV=1.
- o_Pkt_Valid  out  1  a checked packet is held in the buffer.
- o_Pkt_Len  out  LW  payload length of the held packet.
- i_Rd_Addr  in  AW  read address into the payload buffer.
- o_Rd_Data  out  8  registered read data.
- i_Pkt_Ack  in  1  consumer releases the held packet.
- o_Err_Pulse  out  1  one-cycle pulse when a frame is dropped.
- o_Err_Code  out  2  reason for the last drop; holds until the next error.
  - 01 checksum, 10 bad length, 11 timeout.
- o_Overrun  out  1  one-cycle pulse when a byte arrives while a packet is held.

## Operation
- Frame format: 0xA5 sync, LEN, LEN payload bytes, CHK.
- CHK = (LEN + sum of payload bytes) mod 256, accumulated in an 8-bit wrapping register.
- State machine: HUNT, LEN, PAYLOAD, CHECK, HOLD.
- HUNT:
  - on DV with byte 0xA5, go to LEN.
  - all other bytes are silently ignored (no error).
- LEN:
  - on DV with byte in 1..MAX_PAYLOAD: store the length, set sum=byte, byte index=0, go to PAYLOAD.
  - on DV with any other byte (including 0x00 and 0xA5): error code 10, go to HUNT.
- PAYLOAD:
  - on DV, write the byte to buf[index], add it to the sum, increment the index.
  - when index reaches LEN-1 on that write, go to CHECK.
- CHECK:
  - on DV, compare the byte with the sum.
  - equal: set o_Pkt_Valid=1, o_Pkt_Len=LEN, go to HOLD.
  - not equal: error code 01, go to HUNT.
- HOLD:
  - on DV, drop the byte and pulse o_Overrun; stay in HOLD.
  - on i_Pkt_Ack=1, clear o_Pkt_Valid and go to HUNT.
  - if DV and Ack occur in the same cycle, the byte is dropped and o_Overrun pulses.
- Timeout:
  - a counter is cleared by every DV and in HUNT/HOLD, and counts every cycle in LEN/PAYLOAD/CHECK.
  - when it reaches TIMEOUT_CLKS-1: error code 11, go to HUNT.
  - if DV arrives in that same cycle, the DV wins and the timeout does not fire.
- i_Pkt_Ack outside HOLD is ignored.
- Read port:
  - o_Rd_Data <= buf[i_Rd_Addr] every cycle, regardless of state.
  - addresses >= MAX_PAYLOAD return 0x00.
  - addresses in range but >= o_Pkt_Len return stale contents.
- Buffer contents are written only in PAYLOAD, so a held packet is never corrupted.

## Timing
- Reset values:
  - state=HUNT.
  - o_Pkt_Valid=0, o_Pkt_Len=0, o_Rd_Data=0x00.
  - o_Err_Pulse=0, o_Err_Code=00, o_Overrun=0.
  - sum, index and timeout counter =0.
  - Buffer contents are not reset.
- Reset asserted mid-frame or in HOLD returns to HUNT immediately (asynchronously); the partial or held packet is lost with no error pulse.
- o_Pkt_Valid rises on the clock edge that samples the DV of a correct CHK; it is visible the cycle after the strobe.
- o_Pkt_Valid falls on the edge that samples i_Pkt_Ack.
- A 0xA5 arriving on the cycle after the Ack is accepted as a new sync.
- o_Err_Pulse, o_Err_Code and o_Overrun all update on the edge that samples the offending DV or the timeout.
- Read latency is exactly 1 cycle from i_Rd_Addr to o_Rd_Data.
- Minimum spacing between DVs is 1 cycle; the block accepts a DV on every cycle.

## Test plan
- Good frame: send A5 03 10 20 30 63 -> o_Pkt_Valid=1 and o_Pkt_Len=3 one cycle after the last DV; reads of addresses 0,1,2 return 10,20,30 one cycle later; Ack -> Valid=0.
- Checksum wrap and errors:
  - A5 02 FF FF 00 -> packet accepted.
  - A5 03 10 20 30 64 -> o_Err_Pulse for one cycle, o_Err_Code=01, Valid stays 0.
- Bad length:
  - A5 00 -> code 10.
  - A5 11 (MAX_PAYLOAD=16) -> code 10.
  - A5 10 followed by 16 bytes and a correct CHK -> accepted with o_Pkt_Len=16.
- Timeout: A5 02 10, then idle for TIMEOUT_CLKS cycles -> code 11 on the exact cycle; a following A5 01 07 08 is accepted.
- Overrun: while held, send 0x55 -> o_Overrun pulses once and buffer data is unchanged; DV and Ack in the same cycle -> overrun pulse, state HUNT, that byte is not treated as a sync.
- Reset and noise:
  - noise 00 FF 3C before A5 -> ignored, no error.
  - i_Rst_n low mid-PAYLOAD -> all outputs at reset values asynchronously.
  - after release, a full good frame is accepted.
